register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_SPACE, default 5, address width in bits.
REQ-003 Parameter REG_AMOUNT, default 32, number of architectural registers (<= 2**ADDR_SPACE).
REQ-004 Parameter ZERO_REGISTER, default 5'b00000, address of the hardwired-zero register.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 r1_addr  input  ADDR_SPACE  read port 1 address.
REQ-009 r2_addr  input  ADDR_SPACE  read port 2 address.
REQ-010 wr_addr  input  ADDR_SPACE  write port address.
REQ-011 wr_en  input  1  write enable.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 r1_data  output  WIDTH  read port 1 data.
REQ-014 r2_data  output  WIDTH  read port 2 data.

Function
REQ-015 The block SHALL hold REG_AMOUNT registers of WIDTH bits each.
REQ-016 On a rising clk edge with rst=0 and wr_en=1, the block SHALL store wr_data into the register at wr_addr.
REQ-017 With wr_en=0, no register SHALL change.
REQ-018 Writes to ZERO_REGISTER SHALL be discarded; reads of ZERO_REGISTER SHALL always return 0.
REQ-019 Both read ports SHALL be combinational (zero-cycle latency), independent, and able to read the same or different addresses simultaneously.
REQ-020 A value written at edge N SHALL appear on any read port addressing that register immediately after edge N.
REQ-021 Addresses >= REG_AMOUNT SHALL read as 0; writes to them SHALL be discarded.
REQ-022 Without bypass (see Configuration), a read of wr_addr in the same cycle as the write SHALL return the old contents until the edge.

Reset
REQ-023 On a rising clk edge with rst=1, all registers SHALL be cleared to 0; r1_data and r2_data SHALL then read 0 for all addresses.
REQ-024 rst SHALL take priority over wr_en; a write coincident with reset SHALL be lost.
REQ-025 Before the first reset edge, register contents are undefined; the zero register SHALL still read 0.

Configuration
REQ-026 Macro RF_WRITE_BYPASS_EN: when defined, a read port whose address equals wr_addr while wr_en=1, rst=0, and the address is not ZERO_REGISTER and < REG_AMOUNT, SHALL output wr_data combinationally in the same cycle.
REQ-027 When RF_WRITE_BYPASS_EN is undefined, no bypass path SHALL exist and REQ-022 applies.

Verification
REQ-028 Reset, then read r1_addr=0..31 and r2_addr=31..0 -> all reads 0.
REQ-029 wr_addr=3, wr_data=59, wr_en=1, r1_addr=3, one clock -> r1_data=59; r2_addr=3 -> r2_data=59.
REQ-030 wr_addr=0, wr_data=32'hFFFFFFFF, wr_en=1, one clock -> r1_data at address 0 = 0.
REQ-031 Write 7 to r5, then wr_en=0 with wr_data=99 to r5, one clock -> r5 still reads 7.
REQ-032 Write 32'hDEADBEEF to r31, assert rst with wr_en=1 to r31 (data 1) for one edge -> r31 reads 0.
REQ-033 With RF_WRITE_BYPASS_EN defined, wr_addr=9, wr_data=123, wr_en=1, r1_addr=9 before the edge -> r1_data=123; without the macro -> r1_data = old value (0 after reset).

Source files
------------

// File: rtl/register_file.sv
// Multi-ported register file with two combinational read ports and one synchronous write port.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_WRITE_BYPASS_EN.
module register_file #(
    parameter int                    WIDTH         = 32,
    parameter int                    ADDR_SPACE    = 5,
    parameter int                    REG_AMOUNT    = 32,
    parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = 5'b00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_SPACE-1:0] r1_addr,
    input  logic [ADDR_SPACE-1:0] r2_addr,
    input  logic [ADDR_SPACE-1:0] wr_addr,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      r1_data,
    output logic [WIDTH-1:0]      r2_data
);

    // One extra bit so the limit itself is representable when REG_AMOUNT == 2**ADDR_SPACE.
    localparam logic [ADDR_SPACE:0] REG_LIMIT = (ADDR_SPACE + 1)'(REG_AMOUNT);

    logic [WIDTH-1:0] regs_reg [REG_AMOUNT];
    logic             wr_valid;

    assign wr_valid = (wr_addr != ZERO_REGISTER) && ({1'b0, wr_addr} < REG_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_AMOUNT; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && wr_valid) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_read
            logic [ADDR_SPACE-1:0] addr;
            logic                  addr_ok;
            logic [WIDTH-1:0]      data;

            assign addr    = (gi == 0) ? r1_addr : r2_addr;
            // The zero register is masked here so it reads 0 even before the first reset.
            assign addr_ok = (addr != ZERO_REGISTER) && ({1'b0, addr} < REG_LIMIT);

`ifdef RF_WRITE_BYPASS_EN
            logic bypass_hit;
            assign bypass_hit = wr_en && !rst && wr_valid && (addr == wr_addr);

            always_comb begin
                data = '0;
                if (bypass_hit) begin
                    data = wr_data;
                end else if (addr_ok) begin
                    data = regs_reg[addr];
                end
            end
`else
            always_comb begin
                data = '0;
                if (addr_ok) begin
                    data = regs_reg[addr];
                end
            end
`endif
        end
    endgenerate

    assign r1_data = g_read[0].data;
    assign r2_data = g_read[1].data;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read values are queued when a transaction is
// driven and compared on the following falling edge, before the write edge commits.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  r1_addr;
    logic [4:0]  r2_addr;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] r1_data;
    logic [31:0] r2_data;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .r1_addr (r1_addr),
        .r2_addr (r2_addr),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .r1_data (r1_data),
        .r2_data (r2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [32];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic r,
                                               input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef RF_WRITE_BYPASS_EN
        if (!r && we && (a == wa)) return wd;
`endif
        return model[a];
    endfunction

    // Drives one cycle of stimulus just after a rising edge, checks the combinational
    // reads at the falling edge, then lets the model follow the rising edge.
    task automatic xfer(input string tag, input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd; r1_addr = a1; r2_addr = a2;
        e.e1 = model_read(a1, r, we, wa, wd);
        e.e2 = model_read(a2, r, we, wa, wd);
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d %s rst=%b we=%b wa=%0d wd=%h a1=%0d a2=%0d r1=%h r2=%h",
                 n_txn, tag, r, we, wa, wd, a1, a2, r1_data, r2_data);
        check($sformatf("%s.r1", tag), r1_data, e.e1);
        check($sformatf("%s.r2", tag), r2_data, e.e2);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; r1_addr = '0; r2_addr = '0;
        @(posedge clk);
        #1;

        // Zero register reads 0 before any reset; a pre-reset write must be wiped by reset.
        xfer("pre_zero", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        xfer("pre_wr", 1'b0, 1'b1, 5'd10, 32'hAAAA5555, 5'd0, 5'd0);
        xfer("reset", 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        for (int i = 0; i < 32; i++) begin
            xfer("rst_sweep", 1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
        end

        xfer("wr3", 1'b0, 1'b1, 5'd3, 32'd59, 5'd3, 5'd3);
        xfer("rd3", 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);

        xfer("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        xfer("rd0", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3);

        xfer("wr5", 1'b0, 1'b1, 5'd5, 32'd7, 5'd1, 5'd2);
        xfer("nowr5", 1'b0, 1'b0, 5'd5, 32'd99, 5'd5, 5'd5);
        xfer("rd5", 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd3);

        xfer("byp9", 1'b0, 1'b1, 5'd9, 32'd123, 5'd9, 5'd5);
        xfer("rd9", 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);

        xfer("wr31", 1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 5'd0, 5'd0);
        xfer("rd31", 1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd3);
        xfer("rst_wr31", 1'b1, 1'b1, 5'd31, 32'd1, 5'd31, 5'd31);
        xfer("rd31_post", 1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd9);

        for (int i = 0; i < 200; i++) begin
            logic [4:0] wa;
            logic [4:0] a1;
            logic [4:0] a2;
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            xfer("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wa,
                 $urandom, a1, a2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
